ad9252_align: RTL

- Per-lane training controller for the AD9252 LVDS receive path; runs in the frame-clock domain.
- Directly downstream of the lane deserializer: watches its 14-bit parallel word while the ADC sends a fixed test pattern.
- Drives the deserializer's IDELAY load/tap inputs and BITSLIP input.
- Scans all 32 delay taps, centres the tap in the widest stable data eye, then bit-slips until the word equals the training pattern.

---
 rtl/ad9252_pkg.sv | 28 ++
 rtl/ad9252_window_track.sv | 64 ++++++
 rtl/ad9252_align.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ad9252_pkg.sv
// Shared types and constants for the AD9252 lane training controller.
// Holds the FSM state enum, word/tap widths and default test patterns.
package ad9252_pkg;

    localparam int TAP_W    = 5;
    localparam int WORD_W   = 14;
    localparam int NUM_TAPS = 32;
    localparam int LEN_W    = 6;

    localparam logic [WORD_W-1:0] PAT_DEFAULT = 14'h2A3C;
    localparam logic [WORD_W-1:0] PAT_CHECKER = 14'h2AAA;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SETTLE,
        SAMPLE,
        NEXT_TAP,
        SET_BEST,
        BEST_SETTLE,
        CHECK,
        SLIP,
        SLIP_WAIT,
        DONE,
        FAIL
    } align_state_t;

endpackage

// File: rtl/ad9252_window_track.sv
// Tracks the widest run of consecutive stable taps during a delay scan.
// Ports: clk/rst, clear (new scan), strobe+stable+tap+last per tap,
// best_start/best_len (earliest widest run; ties keep the earlier one).
module ad9252_window_track
    import ad9252_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             strobe,
    input  logic             stable,
    input  logic             last,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len
);

    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;
    logic [TAP_W-1:0] cand_start;
    logic [LEN_W-1:0] cand_len;
    logic             close_run;

    // A stable final tap still has to close the run, since windows
    // never wrap from tap 31 back to tap 0.
    always_comb begin
        cand_start = run_start;
        cand_len   = run_len;
        close_run  = 1'b1;
        if (stable) begin
            if (run_len == '0) begin
                cand_start = tap;
            end
            cand_len  = run_len + 1'b1;
            close_run = last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clear) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (strobe) begin
            if (close_run) begin
                if (cand_len > best_len) begin
                    best_start <= cand_start;
                    best_len   <= cand_len;
                end
                run_len <= '0;
            end else begin
                run_start <= cand_start;
                run_len   <= cand_len;
            end
        end
    end

endmodule

// File: rtl/ad9252_align.sv
// Per-lane AD9252 training: scans 32 IDELAY taps, centres in the widest
// stable eye, then bit-slips until the word matches train_pattern.
// Ports: ad_dco_fc/reset, start, ad_data_para, train_pattern in;
// bit_slip, delay_ld/ce/inc, cntvaluein, busy, aligned, align_fail,
// win_len, slip_count out.
module ad9252_align
    import ad9252_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int COMPARE_CYCLES = 64,
    parameter int MIN_WINDOW     = 4,
    parameter int MAX_SLIPS      = 14,
    parameter int DEFAULT_TAP    = 16
) (
    input  logic              ad_dco_fc,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] ad_data_para,
    input  logic [WORD_W-1:0] train_pattern,
    output logic              bit_slip,
    output logic              delay_ld,
    output logic              delay_ce,
    output logic              delay_inc,
    output logic [TAP_W-1:0]  cntvaluein,
    output logic              busy,
    output logic              aligned,
    output logic              align_fail,
    output logic [LEN_W-1:0]  win_len,
    output logic [3:0]        slip_count
);

    localparam logic [6:0]       SETTLE_LAST = 7'(SETTLE_CYCLES - 1);
    localparam logic [6:0]       CMP_LAST    = 7'(COMPARE_CYCLES - 1);
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_WINDOW);
    localparam logic [3:0]       SLIP_MAX    = 4'(MAX_SLIPS);

    align_state_t      state;
    align_state_t      state_next;
    logic [6:0]        cnt;
    logic [TAP_W-1:0]  tap;
    logic [WORD_W-1:0] ref_word;
    logic [WORD_W-1:0] target;
    logic              miss;
    logic              miss_next;
    logic              start_ok;
    logic [TAP_W-1:0]  best_start;
    logic [LEN_W-1:0]  best_len;

    assign delay_ce   = 1'b0;
    assign delay_inc  = 1'b0;
    assign cntvaluein = tap;

    // The first scan sample only captures the reference; pattern checks
    // compare every sample including the first.
    always_comb begin
        target = (state == CHECK) ? train_pattern : ref_word;
        if (cnt == '0) begin
            miss_next = (state == CHECK) && (ad_data_para != target);
        end else begin
            miss_next = miss | (ad_data_para != target);
        end
    end

    always_ff @(posedge ad_dco_fc or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        aligned    = 1'b0;
        align_fail = 1'b0;
        start_ok   = 1'b0;
        unique case (state)
            IDLE, DONE, FAIL: begin
                busy       = 1'b0;
                aligned    = (state == DONE);
                align_fail = (state == FAIL);
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = SETTLE;
            SETTLE: begin
                if (cnt == SETTLE_LAST) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (cnt == CMP_LAST) state_next = NEXT_TAP;
            end
            NEXT_TAP: begin
                state_next = (tap == LAST_TAP) ? SET_BEST : LOAD;
            end
            SET_BEST: begin
                state_next = (best_len < MIN_LEN) ? FAIL : BEST_SETTLE;
            end
            BEST_SETTLE: begin
                if (cnt == SETTLE_LAST) state_next = CHECK;
            end
            CHECK: begin
                if (cnt == CMP_LAST) begin
                    if (!miss_next) begin
                        state_next = DONE;
                    end else if (slip_count == SLIP_MAX) begin
                        state_next = FAIL;
                    end else begin
                        state_next = SLIP;
                    end
                end
            end
            SLIP: state_next = SLIP_WAIT;
            SLIP_WAIT: begin
                if (cnt == SETTLE_LAST) state_next = CHECK;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulses are registered against state_next so each one is high for
    // exactly the first cycle of its state, alongside the new tap value.
    always_ff @(posedge ad_dco_fc or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            tap        <= DEF_TAP;
            ref_word   <= '0;
            miss       <= 1'b0;
            win_len    <= '0;
            slip_count <= '0;
            delay_ld   <= 1'b0;
            bit_slip   <= 1'b0;
        end else begin
            cnt      <= (state_next != state) ? 7'd0 : cnt + 7'd1;
            delay_ld <= (state_next == LOAD);
            bit_slip <= (state_next == SLIP);
            if (start_ok) begin
                tap        <= '0;
                slip_count <= '0;
            end
            if (state == NEXT_TAP && state_next == LOAD) begin
                tap <= tap + 1'b1;
            end
            if (state == SAMPLE && cnt == '0) begin
                ref_word <= ad_data_para;
            end
            if (state == SAMPLE || state == CHECK) begin
                miss <= miss_next;
            end
            if (state == SET_BEST) begin
                win_len  <= best_len;
                delay_ld <= 1'b1;
                tap      <= best_start + best_len[LEN_W-1:1];
            end
            if (state == SLIP) begin
                slip_count <= slip_count + 4'd1;
            end
            if (state_next == FAIL && state != FAIL) begin
                tap      <= DEF_TAP;
                delay_ld <= 1'b1;
            end
        end
    end

    ad9252_window_track u_window_track (
        .clk        (ad_dco_fc),
        .rst        (reset),
        .clear      (start_ok),
        .strobe     (state == NEXT_TAP),
        .stable     (!miss),
        .last       (tap == LAST_TAP),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

endmodule
